// File: rtl/prefix_adder_seq_pkg.sv
// Shared definitions for the multi-word prefix-adder sequencer: state encoding and index sizing.
package prefix_adder_seq_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN,
        DONE = S_DONE
    } state_t;

    // Word index width: clog2(words), never narrower than one bit.
    function automatic int idx_width(input int words);
        return (words <= 2) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/prefix_adder_sequencer_if.sv
// Operand/result handshake bundle between producer, sequencer and consumer.
interface prefix_adder_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
);
    localparam int N = WIDTH * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic         carry_in;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         carry_out;
    logic         busy;

    modport master (
        output in_valid, carry_in, a, b, out_ready,
        input  in_ready, out_valid, sum, carry_out, busy
    );

    modport slave (
        input  in_valid, carry_in, a, b, out_ready,
        output in_ready, out_valid, sum, carry_out, busy
    );

endinterface

// File: rtl/prefix_adder.sv
// Kogge-Stone parallel-prefix adder of WIDTH = 2**LEVELS bits with carry in/out.
// Purely combinational; no handshake.
module prefix_adder #(
    parameter int LEVELS = 3,
    parameter int WIDTH  = 2 ** LEVELS
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_z,
    output logic             o_cout
);

    logic [WIDTH-1:0] w_g [0:LEVELS];
    logic [WIDTH-1:0] w_p [0:LEVELS];
    logic [WIDTH:0]   w_c;

    // Each level doubles the span; low bits below the span keep their previous group terms.
    always_comb begin
        w_g[0] = i_a & i_b;
        w_p[0] = i_a ^ i_b;
        for (int l = 0; l < LEVELS; l++) begin
            w_g[l+1] = w_g[l] | (w_p[l] & (w_g[l] << (1 << l)));
            w_p[l+1] = w_p[l] & ((w_p[l] << (1 << l)) | ~({WIDTH{1'b1}} << (1 << l)));
        end
        w_c = {w_g[LEVELS] | (w_p[LEVELS] & {WIDTH{i_cin}}), i_cin};
    end

    assign o_z    = w_p[0] ^ w_c[WIDTH-1:0];
    assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/prefix_adder_sequencer.sv
// Adds two WORDS*WIDTH operands one word per cycle through one shared prefix_adder; result valid WORDS cycles after accept.
// in_ready only in IDLE; result held in DONE until out_ready.
module prefix_adder_sequencer
    import prefix_adder_seq_pkg::*;
#(
    parameter int LEVELS = 3,
    parameter int WIDTH  = 2 ** LEVELS,
    parameter int WORDS  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    prefix_adder_sequencer_if.slave bus
);

    localparam int N  = WORDS * WIDTH;
    localparam int IW = idx_width(WORDS);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_sum;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic [WIDTH-1:0] w_z;
    logic            w_cout;
    logic [N+WIDTH-1:0] w_sum_cat;
    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_busy;

    prefix_adder #(
        .LEVELS (LEVELS),
        .WIDTH  (WIDTH)
    ) u_adder (
        .i_a    (r_a[WIDTH-1:0]),
        .i_b    (r_b[WIDTH-1:0]),
        .i_cin  (r_carry),
        .o_z    (w_z),
        .o_cout (w_cout)
    );

    // New word enters at the top so word 0 lands at the bottom after WORDS shifts.
    assign w_sum_cat = {w_z, r_sum};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (r_idx == IW'(WORDS - 1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.carry_in;
                        r_sum   <= '0;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_cat[N+WIDTH-1:WIDTH];
                    r_carry <= w_cout;
                    r_a     <= r_a >> WIDTH;
                    r_b     <= r_b >> WIDTH;
                    r_idx   <= r_idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_carry;

endmodule

// File: tb/tb_prefix_adder_sequencer.sv
// Bench for prefix_adder_sequencer (LEVELS=3, WIDTH=8, WORDS=4): directed table, corner sequences, random scoreboard.
module tb_prefix_adder_sequencer;

    localparam int LEVELS = 3;
    localparam int WIDTH  = 8;
    localparam int WORDS  = 4;
    localparam int NRAND  = 1000;
    localparam int LIMIT  = 40000;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    prefix_adder_sequencer_if #(.WIDTH(WIDTH), .WORDS(WORDS)) bus ();

    prefix_adder_sequencer #(
        .LEVELS (LEVELS),
        .WIDTH  (WIDTH),
        .WORDS  (WORDS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        co;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic [31:0] es, input logic ec);
        int   lat;
        logic rdy_seen;
        chk({nm, "_in_ready_idle"}, 64'(bus.in_ready), 64'd1);
        bus.a         = a;
        bus.b         = b;
        bus.carry_in  = ci;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat      = 0;
        rdy_seen = 1'b0;
        while (!bus.out_valid && lat < 20) begin
            rdy_seen |= bus.in_ready;
            tick();
            lat++;
        end
        rdy_seen |= bus.in_ready;
        chk({nm, "_latency"}, 64'(lat), 64'(WORDS));
        chk({nm, "_in_ready_low"}, 64'(rdy_seen), 64'd0);
        chk({nm, "_busy"}, 64'(bus.busy), 64'd1);
        chk({nm, "_sum"}, 64'(bus.sum), 64'(es));
        chk({nm, "_carry_out"}, 64'(bus.carry_out), 64'(ec));
        tick();
        chk({nm, "_in_ready_after"}, 64'(bus.in_ready), 64'd1);
        chk({nm, "_out_valid_after"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        int          lat;
        int          sent;
        int          recv;
        int          cyc;
        logic        acc;
        logic        dn;
        logic        hold;
        logic [32:0] got;
        logic [32:0] prev_got;
        logic [32:0] q [$];

        n_chk  = 0;
        n_fail = 0;

        tbl[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
        tbl[2] = '{32'h00FF_00FF, 32'h0001_0001, 1'b1, 32'h0100_0101, 1'b0};
        tbl[3] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        tbl[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        tbl[6] = '{32'h0000_FFFF, 32'h0000_FF01, 1'b0, 32'h0001_FF00, 1'b0};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.carry_in  = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_sum", 64'(bus.sum), 64'd0);
        chk("rst_carry_out", 64'(bus.carry_out), 64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, tbl[i].co);
        end

        // Backpressure: result must hold for 10 stalled cycles while the producer pokes in_valid.
        bus.a         = 32'h1234_5678;
        bus.b         = 32'h1111_1111;
        bus.carry_in  = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_latency", 64'(lat), 64'(WORDS));
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = k[0];
            bus.a        = $urandom;
            bus.b        = $urandom;
            bus.carry_in = 1'($urandom_range(0, 1));
            tick();
            chk($sformatf("bp_out_valid%0d", k), 64'(bus.out_valid), 64'd1);
            chk($sformatf("bp_sum%0d", k), 64'(bus.sum), 64'h2345_6789);
            chk($sformatf("bp_carry%0d", k), 64'(bus.carry_out), 64'd0);
            chk($sformatf("bp_in_ready%0d", k), 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        chk("bp_no_accept_busy", 64'(bus.busy), 64'd0);

        // Reset during the second RUN cycle must discard the carry chain.
        bus.a         = 32'hFFFF_FFFF;
        bus.b         = 32'h0000_0001;
        bus.carry_in  = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_sum", 64'(bus.sum), 64'd0);
        chk("mid_rst_carry", 64'(bus.carry_out), 64'd0);
        do_op("post_rst", 32'd5, 32'd7, 1'b0, 32'h0000_000C, 1'b0);

        // Random traffic against an arithmetic reference and an in-order queue.
        sent     = 0;
        recv     = 0;
        cyc      = 0;
        hold     = 1'b0;
        prev_got = '0;
        bus.in_valid = 1'b0;
        while ((sent < NRAND || recv < NRAND) && cyc < LIMIT) begin
            if (!bus.in_valid && sent < NRAND && $urandom_range(0, 3) != 0) begin
                bus.a        = $urandom;
                bus.b        = $urandom;
                bus.carry_in = 1'($urandom_range(0, 1));
                bus.in_valid = 1'b1;
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if (hold) begin
                chk("rand_out_valid_hold", 64'(bus.out_valid), 64'd1);
                chk("rand_result_stable", 64'({bus.carry_out, bus.sum}), 64'(prev_got));
            end
            acc  = bus.in_valid && bus.in_ready;
            dn   = bus.out_valid && bus.out_ready;
            got  = {bus.carry_out, bus.sum};
            hold = bus.out_valid && !bus.out_ready;
            prev_got = got;
            if (acc) begin
                q.push_back({1'b0, bus.a} + {1'b0, bus.b} + 33'(bus.carry_in));
            end
            tick();
            cyc++;
            if (acc) begin
                sent++;
                bus.in_valid = 1'b0;
            end
            if (dn) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected_result", 64'(got), 64'h1_0000_0000_0000);
                end else begin
                    chk($sformatf("rand_result%0d", recv), 64'(got), 64'(q.pop_front()));
                end
                recv++;
            end
        end
        chk("rand_timeout", 64'(cyc < LIMIT), 64'd1);
        chk("rand_recv_count", 64'(recv), 64'(NRAND));
        chk("rand_queue_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prefix_adder_sequencer.md
# prefix_adder_sequencer

Multi-word addition controller that time-shares a single `prefix_adder` instance, LEVELS/WIDTH as configured, to add two operands of WORDS×WIDTH bits. Processing is one word per cycle, least-significant word first. The word carry is registered between cycles, so one narrow adder handles wide operands. The block sits between a valid/ready producer and a valid/ready consumer in the arithmetic datapath.

## Interface
Parameters:
- LEVELS, 3, prefix tree depth, passed to `prefix_adder`
- WIDTH, 2**LEVELS, word width of the shared adder
- WORDS, 4, words per operand; total operand width N = WORDS*WIDTH; WORDS ≥ 1

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operand pair offered
- in_ready  out  1  block can accept an operand pair
- carry_in  in  1  carry into word 0
- a  in  N  operand A
- b  in  N  operand B
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- sum  out  N  A + B + carry_in, modulo 2**N
- carry_out  out  1  carry out of the top word
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b into operand shift registers; latch carry_in into the carry register; clear word index; clear sum; go to RUN.
- RUN:
  - The adder receives the low word of each operand shift register and the carry register.
  - Each cycle: the adder z word shifts into sum from the top (after WORDS shifts, word 0 sits in the low word); the carry register takes the adder carry_out; operand registers shift right by WIDTH; index increments.
  - When index==WORDS-1 (the last word is added this cycle), go to DONE.
- DONE:
  - out_valid=1; sum and carry_out (the carry register) held stable.
  - On out_ready: go to IDLE.
- Handshake rules:
  - in_ready is 0 in RUN and DONE; in_valid there is ignored and operands must be held by the producer.
  - out_ready outside DONE is ignored.
  - out_valid never drops without out_ready.
- Arithmetic: unsigned; exact modulo 2**N; carry_out is bit N of a+b+carry_in. Signed overflow is not reported.
- Reset:
  - Reset at any time, including mid-RUN or in DONE, forces IDLE next edge.
  - Reset clears index, carry register, sum, carry_out and out_valid; in_ready=1 after the edge.
  - An in-flight operation is discarded with no output. No stale carry survives.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, carry_out=0.
- Accept at edge E0 → RUN for WORDS cycles → out_valid=1 after edge E0+WORDS. Latency is WORDS cycles from acceptance to valid result.
- Result handshake at edge E1 → in_ready=1 after E1. Next acceptance earliest at edge E1+1.
- Throughput: one operation per WORDS+2 cycles with a ready consumer.
- Combinational paths:
  - in_ready, out_valid and busy are decoded from registered state only.
  - There are no combinational paths from inputs to outputs.
- WORDS=1: RUN lasts one cycle; the behaviour is otherwise identical.

## Structure
- Shared package/include `prefix_adder_seq_pkg` holds:
  - the state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the index width function (clog2 of WORDS, minimum 1).
- One sub-module: `prefix_adder` (LEVELS, WIDTH), instantiated once as the shared datapath.
- Inside this block: the FSM, index counter, operand/sum shift registers and carry register.

## Test plan
Configuration: LEVELS=3, WIDTH=8, WORDS=4 (N=32).
- Basic add: a=0x00000001, b=0x00000002, carry_in=0, out_ready=1. Required: sum=0x00000003, carry_out=0, out_valid rising exactly 4 edges after acceptance, in_ready low throughout.
- Full ripple: a=0xFFFFFFFF, b=0x00000001, carry_in=0. Required: sum=0x00000000, carry_out=1, with the carry propagating through all 4 word cycles.
- Carry-in: a=0x00FF00FF, b=0x00010001, carry_in=1. Required: sum=0x01000101, carry_out=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE and toggle in_valid with new operands.
  - During the stall: out_valid stays 1, sum and carry_out are stable, in_ready stays 0, no new acceptance.
  - On out_ready=1: after one edge, in_ready=1.
- Reset mid-RUN: start 0xFFFFFFFF+0x00000001, assert reset on the second RUN cycle.
  - Required next edge: in_ready=1, out_valid=0, sum=0.
  - Follow with a=5, b=7, carry_in=0 → sum=0x0000000C, carry_out=0 (no stale carry).
- Randomized back-to-back: 1000 random (a, b, carry_in) with random out_ready stalls. Each result must match the reference model a+b+carry_in as 33 bits, in order, with no lost or duplicated transactions.
